vga_display_ctrl: RTL and testbench
===================================

# vga_display_ctrl

Display back-end for the rhythm game: generates 640x480@60 Hz VGA timing from the 100 MHz system clock and publishes the current pixel coordinate to the layer generators. It samples the 12-bit RGB444 word from the layer mixer and drives the VGA pins, with sync signals pipelined to match the layer-generator lookup latency. It is the consumer end of the mixer's `Data` interface.

## Interface
- `CLK_DIV`, 4: system clocks per pixel (100 MHz to 25 MHz).
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `PIPE_LAT`, 1: pixel ticks between a `pix_x`/`pix_y` presentation and valid `Data`. Legal range 0..3.
- `clk` input 1: system clock, 100 MHz.
- `rst_n` input 1: asynchronous, active-low reset.
- `Data` input 12: mixer pixel, RGB444 with R in [11:8], G in [7:4], B in [3:0].
- `pix_x` output 10: current horizontal count, 0..H_TOTAL-1.
- `pix_y` output 10: current vertical count, 0..V_TOTAL-1.
- `pix_en` output 1: pixel tick; high for one `clk` every CLK_DIV cycles.
- `frame_start` output 1: one-`clk` pulse at the start of each frame.
- `vga_r`, `vga_g`, `vga_b` output 4 each: registered colour outputs.
- `vga_hs`, `vga_vs` output 1 each: registered syncs, active-low.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. V_TOTAL = 525.
- `div_cnt` counts 0..CLK_DIV-1 and wraps. `pix_en` = (`div_cnt` == CLK_DIV-1), decoded from the register.
- On a `clk` edge with `pix_en`=1:
  - `h_cnt` increments.
  - At H_TOTAL-1, `h_cnt` wraps to 0 and `v_cnt` increments.
  - At V_TOTAL-1 while `h_cnt` wraps, `v_cnt` wraps to 0.
- `pix_x` = `h_cnt`; `pix_y` = `v_cnt`.
- Raw decodes from the counters:
  - active = `h_cnt` < H_ACTIVE && `v_cnt` < V_ACTIVE.
  - hs_raw low for `h_cnt` in [656, 751].
  - vs_raw low for `v_cnt` in [490, 491].
- Alignment pipeline:
  - The (active, hs_raw, vs_raw) triple passes through a PIPE_LAT-deep shift register that advances only on `pix_en`.
  - The output stage also loads only on `pix_en`.
  - `vga_hs`/`vga_vs` take the delayed sync values.
  - `{vga_r, vga_g, vga_b}` take `Data` if delayed active = 1, else 12'h000.
- Blanking overrides `Data` unconditionally: no colour is ever driven outside the active region.
- `frame_start` goes high for one `clk` on the edge where the counters wrap to (0,0), then low on the next edge.
- All counter arithmetic is unsigned. There is no saturation; counters wrap only at their totals.

## Timing
- Reset (`rst_n`=0, asynchronous), all immediate:
  - `div_cnt`, `h_cnt`, `v_cnt` = 0.
  - `pix_en` = 0 (for CLK_DIV > 1).
  - `frame_start` = 0.
  - RGB outputs = 0.
  - `vga_hs` = `vga_vs` = 1.
  - All pipeline stages = inactive, syncs high.
- Reset asserted mid-line or mid-frame aborts the frame. After release, timing restarts from (0,0) with no `frame_start` pulse for that partial start.
- First `pix_en` after reset release occurs on the CLK_DIV-th rising edge.
- Latency: a counter value reaches the pins PIPE_LAT+1 pixel ticks later, i.e. (PIPE_LAT+1)*CLK_DIV `clk` cycles.
- `Data` is sampled only on `pix_en` edges and must be stable in that cycle. Between ticks it is ignored.
- With PIPE_LAT=0, the output stage samples `Data` for the coordinate currently on `pix_x`/`pix_y`.
- Line period: 3200 `clk` cycles. Frame period: 1,680,000 `clk` cycles.

## Test plan
- Reset check: hold `rst_n`=0 for 10 cycles, then release → outputs read the reset values; the first `pix_en` appears on the 4th rising edge; `pix_x` is 1 after that edge.
- Horizontal sync, PIPE_LAT=1: `vga_hs` first falls (PIPE_LAT+1) ticks after `h_cnt` reaches 656, stays low for exactly 96 ticks (384 clks), and repeats every 3200 clks.
- Vertical sync: `vga_vs` is low for exactly 2 lines (6400 clks), starting when `v_cnt`=490 after the pipeline delay.
- Blanking: drive `Data`=12'hFFF constantly → RGB = 0xFFF for exactly 640 ticks per line and 480 lines; RGB = 0 during every porch and sync.
- Latency: drive `Data` = `pix_x`[11:0] delayed by PIPE_LAT ticks → output pixel n equals n for n = 0..639, for PIPE_LAT = 0, 1 and 3.
- Frame wrap and reset: `frame_start` pulses are 1,680,000 clks apart; asserting `rst_n` mid-frame (`v_cnt`=200) forces `vga_vs`=1 and RGB=0 immediately, and timing restarts from (0,0).

Source files
------------

// File: rtl/vga_display_ctrl.sv
// vga_display_ctrl: VGA timing generator and pixel output stage.
// Divides the system clock down to the pixel rate, walks the raster counters,
// publishes the current coordinate to the layer generators and drives the VGA
// pins with syncs delayed to line up with the mixer's lookup latency.
module vga_display_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] Data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_en,
  output logic        frame_start,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FP;
  localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;

  logic vld_p0, hs_p0, vs_p0;
  logic vld_p1, hs_p1, vs_p1;

  // Forces black whenever the delayed pixel lies outside the visible area.
  function automatic logic [11:0] blank_pixel(input logic vld, input logic [11:0] pix);
    return vld ? pix : 12'h000;
  endfunction

  assign pix_en = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign pix_x  = h_cnt;
  assign pix_y  = v_cnt;

  // Pixel-rate divider and raster counters; frame_start flags the wrap to (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= pix_en ? '0 : div_cnt + DIV_W'(1);
      frame_start <= 1'b0;
      if (pix_en) begin
        if (h_cnt == 10'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          if (v_cnt == 10'(V_TOTAL - 1)) begin
            v_cnt       <= '0;
            frame_start <= 1'b1;
          end else begin
            v_cnt <= v_cnt + 10'd1;
          end
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  // Stage p0: raw decodes straight from the counters
  assign vld_p0 = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
  assign hs_p0  = !((h_cnt >= 10'(HS_FIRST)) && (h_cnt <= 10'(HS_LAST)));
  assign vs_p0  = !((v_cnt >= 10'(VS_FIRST)) && (v_cnt <= 10'(VS_LAST)));

  // Stage p1: decodes delayed by PIPE_LAT pixel ticks to match the mixer
  generate
    if (PIPE_LAT > 0) begin : g_align
      logic [PIPE_LAT-1:0] vld_sr;
      logic [PIPE_LAT-1:0] hs_sr;
      logic [PIPE_LAT-1:0] vs_sr;

      // Shift the decoded triple one slot per pixel tick; reset state is blank.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_sr <= '0;
          hs_sr  <= '1;
          vs_sr  <= '1;
        end else if (pix_en) begin
          vld_sr[0] <= vld_p0;
          hs_sr[0]  <= hs_p0;
          vs_sr[0]  <= vs_p0;
          for (int i = 1; i < PIPE_LAT; i++) begin
            vld_sr[i] <= vld_sr[i-1];
            hs_sr[i]  <= hs_sr[i-1];
            vs_sr[i]  <= vs_sr[i-1];
          end
        end
      end

      assign vld_p1 = vld_sr[PIPE_LAT-1];
      assign hs_p1  = hs_sr[PIPE_LAT-1];
      assign vs_p1  = vs_sr[PIPE_LAT-1];
    end else begin : g_no_align
      assign vld_p1 = vld_p0;
      assign hs_p1  = hs_p0;
      assign vs_p1  = vs_p0;
    end
  endgenerate

  // Stage p2: registered pins, loaded once per pixel tick
  // Output register: sample the mixer pixel and syncs on each pixel tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r  <= 4'h0;
      vga_g  <= 4'h0;
      vga_b  <= 4'h0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else if (pix_en) begin
      {vga_r, vga_g, vga_b} <= blank_pixel(vld_p1, Data);
      vga_hs                <= hs_p1;
      vga_vs                <= vs_p1;
    end
  end

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Testbench for vga_display_ctrl: three scaled-down rasters (PIPE_LAT 0, 1, 3)
// plus one full-size 640x480 raster, all compared every clock against a
// reference computed from elapsed clock count since reset release.
module tb_vga_display_ctrl;

  localparam int NI = 4;
  localparam int CD = 4;
  localparam int HA [NI] = '{16, 16, 16, 640};
  localparam int HF [NI] = '{2, 2, 2, 16};
  localparam int HS [NI] = '{4, 4, 4, 96};
  localparam int HB [NI] = '{3, 3, 3, 48};
  localparam int VA [NI] = '{6, 6, 6, 480};
  localparam int VF [NI] = '{1, 1, 1, 10};
  localparam int VS [NI] = '{2, 2, 2, 2};
  localparam int VB [NI] = '{2, 2, 2, 33};
  localparam int PL [NI] = '{0, 1, 3, 1};

  typedef struct {
    int x;
    int y;
    int en;
    int fs;
    int rgb;
    int hs;
    int vs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] data [NI];
  logic [9:0]  px [NI];
  logic [9:0]  py [NI];
  logic        en [NI];
  logic        fs [NI];
  logic [3:0]  r [NI];
  logic [3:0]  g [NI];
  logic [3:0]  b [NI];
  logic        hs [NI];
  logic        vs [NI];

  int unsigned ecnt = 0;
  int          tick_data [NI];
  bit          coord_mode = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_fs = -1;
  int          hs_low = 0;

  always #5 clk = ~clk;

  // Rising edges seen since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  for (genvar k = 0; k < NI; k++) begin : g_dut
    vga_display_ctrl #(
      .CLK_DIV (CD),
      .H_ACTIVE(HA[k]),
      .H_FP    (HF[k]),
      .H_SYNC  (HS[k]),
      .H_BP    (HB[k]),
      .V_ACTIVE(VA[k]),
      .V_FP    (VF[k]),
      .V_SYNC  (VS[k]),
      .V_BP    (VB[k]),
      .PIPE_LAT(PL[k])
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Data       (data[k]),
      .pix_x      (px[k]),
      .pix_y      (py[k]),
      .pix_en     (en[k]),
      .frame_start(fs[k]),
      .vga_r      (r[k]),
      .vga_g      (g[k]),
      .vga_b      (b[k]),
      .vga_hs     (hs[k]),
      .vga_vs     (vs[k])
    );
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int htot(int i);
    return HA[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int ftot(int i);
    return htot(i) * (VA[i] + VF[i] + VS[i] + VB[i]);
  endfunction

  // Colour word that tags a raster position: low 2 bits of line, 10 bits of column.
  function automatic int code_of(int i, int pos);
    return (((pos / htot(i)) & 3) << 10) | ((pos % htot(i)) & 1023);
  endfunction

  // Expected outputs e rising edges after reset release. n pixel ticks have
  // elapsed; the pins show raster position n-1-PIPE_LAT with the Data value
  // presented for tick n.
  function automatic exp_t model(int i, int e, int td);
    exp_t x;
    int ht, ft, n, pos, m, q, hq, vq;
    bit act;
    ht   = htot(i);
    ft   = ftot(i);
    n    = e / CD;
    pos  = n % ft;
    x.x  = pos % ht;
    x.y  = pos / ht;
    x.en = int'(e % CD == CD - 1);
    x.fs = int'((e % CD == 0) && (n > 0) && (pos == 0));
    m    = n - 1 - PL[i];
    if (m < 0) begin
      x.rgb = 0;
      x.hs  = 1;
      x.vs  = 1;
    end else begin
      q     = m % ft;
      hq    = q % ht;
      vq    = q / ht;
      act   = (hq < HA[i]) && (vq < VA[i]);
      x.hs  = int'(!((hq >= HA[i] + HF[i]) && (hq < HA[i] + HF[i] + HS[i])));
      x.vs  = int'(!((vq >= VA[i] + VF[i]) && (vq < VA[i] + VF[i] + VS[i])));
      x.rgb = act ? td : 0;
    end
    return x;
  endfunction

  task automatic check_all();
    exp_t x;
    for (int i = 0; i < NI; i++) begin
      x = model(i, int'(ecnt), tick_data[i]);
      check($sformatf("u%0d.pix_x", i), int'(px[i]), x.x);
      check($sformatf("u%0d.pix_y", i), int'(py[i]), x.y);
      check($sformatf("u%0d.pix_en", i), int'(en[i]), x.en);
      check($sformatf("u%0d.frame_start", i), int'(fs[i]), x.fs);
      check($sformatf("u%0d.rgb", i), int'({r[i], g[i], b[i]}), x.rgb);
      check($sformatf("u%0d.hs", i), int'(hs[i]), x.hs);
      check($sformatf("u%0d.vs", i), int'(vs[i]), x.vs);
    end
  endtask

  // Whole-run properties: frame period on u0, hsync width on the full raster.
  task automatic track();
    if (fs[0]) begin
      if (last_fs >= 0) check("fs_period", int'(ecnt) - last_fs, ftot(0) * CD);
      last_fs = int'(ecnt);
    end
    if (!hs[3]) begin
      hs_low++;
    end else begin
      if (hs_low > 0) check("hs_width", hs_low, HS[3] * CD);
      hs_low = 0;
    end
  endtask

  // Drive Data: a valid value in the cycle before each pixel tick, noise otherwise.
  task automatic drive();
    int t, m;
    for (int i = 0; i < NI; i++) begin
      if (int'(ecnt) % CD == CD - 1) begin
        t = int'(ecnt) / CD + 1;
        m = t - 1 - PL[i];
        if (coord_mode && m >= 0) tick_data[i] = code_of(i, m % ftot(i));
        else                      tick_data[i] = int'($urandom_range(0, 4095));
        data[i] = 12'(tick_data[i]);
      end else begin
        data[i] = 12'($urandom_range(0, 4095));
      end
    end
  endtask

  task automatic apply_reset(input int hold);
    #1 rst_n = 1'b0;
    #1 check_all();
    last_fs = -1;
    hs_low  = 0;
    repeat (hold) @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      check_all();
      track();
      drive();
      @(negedge clk);
    end
  endtask

  initial begin
    exp_t x;
    bit   found;
    for (int i = 0; i < NI; i++) begin
      data[i]      = 12'h000;
      tick_data[i] = 0;
    end

    apply_reset(10);
    coord_mode = 0;
    run_cycles(4000);

    apply_reset(3);
    coord_mode = 1;
    run_cycles(5000);

    apply_reset(2);
    found = 0;
    for (int c = 0; c < 3000 && !found; c++) begin
      x = model(1, int'(ecnt), 0);
      if (x.vs == 0) begin
        found = 1;
      end else begin
        check_all();
        track();
        drive();
        @(negedge clk);
      end
    end
    check("vs_wait", int'(found), 1);
    check_all();
    apply_reset(5);

    run_cycles(int'($urandom_range(500, 2500)));
    apply_reset(2);
    coord_mode = ($urandom_range(0, 1) == 1);
    run_cycles(4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
